router_fsm: RTL and testbench
=============================

# router_fsm

Control state machine of the 1x3 router, directly upstream of the three 16x9 output FIFOs and of the router register block. It decodes the packet header address, then sequences header/payload/parity loading into the selected FIFO. It stalls the source with `busy` while a FIFO is full or still draining a previous packet, and returns to idle on a soft reset of the selected FIFO.

## Interface
No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: source is driving a valid packet byte; deasserts on the parity byte.
- `data_in` in 2: bits [1:0] of the source byte; the header destination address while in DECODE_ADDRESS.
- `fifo_full` in 1: full flag of the currently selected FIFO (muxed by the synchronizer).
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: empty flags of FIFOs 0..2.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: soft-reset pulses of FIFOs 0..2.
- `parity_done` in 1: register block has stored the packet parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` fall while the FSM was stalled.
- `detect_add` out 1: FSM in DECODE_ADDRESS.
- `lfd_state` out 1: load-first-data (header) cycle; drives the FIFO `lfd_state`.
- `ld_state` out 1: loading payload.
- `laf_state` out 1: load-after-full cycle.
- `full_state` out 1: stalled on a full FIFO.
- `rst_int_reg` out 1: parity-check cycle; clears the internal parity register.
- `write_enb_reg` out 1: FIFO write enable from the register block.
- `busy` out 1: source must hold its current byte.

## Operation
- States, 3-bit encoded: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE), CHECK_PARITY_ERROR (CPE).
- Address latch `addr_q[1:0]`: loaded from `data_in` when state is DA and `pkt_valid`=1. Selects which `fifo_empty_x` and `soft_reset_x` are used in all other states.
- Transitions, evaluated in this priority order:
  - **Soft reset:** if state≠DA and `soft_reset_[addr_q]`=1, next state is DA. This overrides all other transitions.
  - **DA:** if `pkt_valid` and `data_in`∈{0,1,2}, go to LFD when `fifo_empty_[data_in]`=1, otherwise to WTE. Address 3, or `pkt_valid`=0, stays in DA.
  - **LFD:** go to LD unconditionally.
  - **LD:** if `fifo_full`, go to FFS; else if !`pkt_valid`, go to LP; else stay.
  - **FFS:** if !`fifo_full`, go to LAF; else stay.
  - **LAF:** if `parity_done`, go to DA; else if `low_pkt_valid`, go to LP; else go to LD.
  - **LP:** go to CPE unconditionally.
  - **CPE:** if `fifo_full`, go to FFS; else go to DA.
  - **WTE:** if `fifo_empty_[addr_q]`, go to LFD; else stay.
- Outputs are Moore, decoded from the state register only:
  - `detect_add`=DA, `lfd_state`=LFD, `ld_state`=LD, `laf_state`=LAF, `full_state`=FFS, `rst_int_reg`=CPE.
  - `write_enb_reg` = LD | LP | LAF.
  - `busy` = LFD | LP | FFS | LAF | WTE | CPE. `busy` is low only in DA and LD.

## Timing
- **Reset:** `reset`=0 forces state DA and `addr_q`=0 asynchronously. Outputs: `detect_add`=1, all other outputs 0.
- **Reset mid-packet:** returns to DA immediately, with no cleanup cycle.
- **Header capture:** header sampled in DA at edge N; `lfd_state`=1 during cycle N+1; first payload write (`ld_state`) in cycle N+2.
- **End of packet:** `pkt_valid` low sampled in LD; LP lasts 1 cycle, then CPE 1 cycle, then DA. Minimum packet-to-packet gap is 2 busy cycles.
- **Soft reset:** a `soft_reset_x` pulse with x≠`addr_q` is ignored. A pulse coinciding with a normal transition wins.
- **Simultaneous `fifo_full` and `pkt_valid` low in LD:** goes to FFS; parity is loaded via LAF→LP.

## Configuration
- `ROUTER_FSM_DBG_EN` defined: adds output port `state_dbg` (out, 3 bits) carrying the raw state encoding.
  - Encoding: DA=0, LFD=1, LD=2, LP=3, FFS=4, LAF=5, WTE=6, CPE=7.
  - `state_dbg` resets to 0.
- Undefined: the port is absent; behaviour is otherwise identical.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles -> `detect_add`=1, `busy`=0, all other outputs 0; release keeps DA while `pkt_valid`=0.
- **Normal packet:** header addr 1, `fifo_empty_1`=1, 10 payload bytes, then `pkt_valid`=0 -> state path DA→LFD→LD×10→LP→CPE→DA; `write_enb_reg` high for 11 cycles; `busy` high in LFD, LP, CPE.
- **Full stall:** `fifo_full`=1 during LD for 3 cycles -> FFS held 3 cycles with `busy`=1 and `write_enb_reg`=0; then one LAF cycle; then LD, with `parity_done`=0 and `low_pkt_valid`=0.
- **Wait for empty:** header addr 2 with `fifo_empty_2`=0 -> WTE with `busy`=1 until `fifo_empty_2`=1, then LFD on the next cycle.
- **Soft reset:** in LD with `addr_q`=0:
  - pulse `soft_reset_1` -> no effect;
  - pulse `soft_reset_0` -> DA on the next edge, with `detect_add`=1.
- **Invalid address:** header addr 3 with `pkt_valid`=1 -> remains in DA, `busy`=0, no write enable; with `ROUTER_FSM_DBG_EN` defined, `state_dbg`=0 throughout.

Source files
------------

// File: rtl/router_fsm_if.sv
// Handshake/status bundle between the 1x3 router control FSM and its
// source, synchronizer, FIFOs and register block.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  // Environment side: source, synchronizer, FIFOs and register block
  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state,
    input  full_state, rst_int_reg, write_enb_reg, busy
  );

  // Control FSM side
  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state,
    output full_state, rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: header decode and FIFO load sequencing.
// Define ROUTER_FSM_DBG_EN to expose the raw state encoding on state_dbg.
module router_fsm (
  input  logic        clk,
  input  logic        reset,
  router_fsm_if.slave bus
`ifdef ROUTER_FSM_DBG_EN
  ,
  output logic [2:0]  state_dbg
`endif
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] addr_r;
  logic       sel_empty_s;
  logic       sel_srst_s;
  logic       hdr_empty_s;

  // Status of the FIFO picked by the latched address
  always_comb begin
    sel_empty_s = 1'b0;
    sel_srst_s  = 1'b0;
    case (addr_r)
      2'd0:    begin sel_empty_s = bus.fifo_empty_0; sel_srst_s = bus.soft_reset_0; end
      2'd1:    begin sel_empty_s = bus.fifo_empty_1; sel_srst_s = bus.soft_reset_1; end
      2'd2:    begin sel_empty_s = bus.fifo_empty_2; sel_srst_s = bus.soft_reset_2; end
      default: begin sel_empty_s = 1'b0;             sel_srst_s = 1'b0;             end
    endcase
  end

  // Empty flag of the FIFO addressed by the incoming header byte
  always_comb begin
    hdr_empty_s = 1'b0;
    case (bus.data_in)
      2'd0:    hdr_empty_s = bus.fifo_empty_0;
      2'd1:    hdr_empty_s = bus.fifo_empty_1;
      2'd2:    hdr_empty_s = bus.fifo_empty_2;
      default: hdr_empty_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= DECODE_ADDRESS;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Header address latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r <= 2'd0;
    end else if ((state_r == DECODE_ADDRESS) && bus.pkt_valid) begin
      addr_r <= bus.data_in;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Next-state logic; a soft reset of the selected FIFO beats every transition
  always_comb begin
    state_nxt_s = state_r;
    if ((state_r != DECODE_ADDRESS) && sel_srst_s) begin
      state_nxt_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (bus.pkt_valid && (bus.data_in != 2'd3)) begin
            state_nxt_s = hdr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end else begin
            state_nxt_s = DECODE_ADDRESS;
          end
        end
        LOAD_FIRST_DATA: state_nxt_s = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full) begin
            state_nxt_s = FIFO_FULL_STATE;
          end else if (!bus.pkt_valid) begin
            state_nxt_s = LOAD_PARITY;
          end else begin
            state_nxt_s = LOAD_DATA;
          end
        end
        FIFO_FULL_STATE: begin
          state_nxt_s = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done) begin
            state_nxt_s = DECODE_ADDRESS;
          end else if (bus.low_pkt_valid) begin
            state_nxt_s = LOAD_PARITY;
          end else begin
            state_nxt_s = LOAD_DATA;
          end
        end
        LOAD_PARITY:        state_nxt_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_nxt_s = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    state_nxt_s = sel_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:            state_nxt_s = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode; busy is low only in DECODE_ADDRESS and LOAD_DATA
  always_comb begin
    bus.detect_add    = (state_r == DECODE_ADDRESS);
    bus.lfd_state     = (state_r == LOAD_FIRST_DATA);
    bus.ld_state      = (state_r == LOAD_DATA);
    bus.laf_state     = (state_r == LOAD_AFTER_FULL);
    bus.full_state    = (state_r == FIFO_FULL_STATE);
    bus.rst_int_reg   = (state_r == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state_r == LOAD_DATA) || (state_r == LOAD_PARITY) ||
                        (state_r == LOAD_AFTER_FULL);
    bus.busy          = (state_r != DECODE_ADDRESS) && (state_r != LOAD_DATA);
  end

`ifdef ROUTER_FSM_DBG_EN
  assign state_dbg = state_r;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; expected output patterns are
// hand-coded per state from the Moore output table.
module tb_router_fsm;
  logic clk;
  logic reset;
  router_fsm_if bus ();
`ifdef ROUTER_FSM_DBG_EN
  logic [2:0] state_dbg;
`endif

  router_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ROUTER_FSM_DBG_EN
    ,
    .state_dbg (state_dbg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0010;
  localparam logic [7:0] O_LP  = 8'b0000_0011;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;
  localparam logic [7:0] O_CPE = 8'b0000_0101;

  int n_checks = 0;
  int n_errors = 0;
  int wen_cnt  = 0;

  logic [7:0] outs_s;
  assign outs_s = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                   bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.write_enb_reg === 1'b1) wen_cnt++;
  endtask

  task automatic header(input logic [1:0] a);
    bus.pkt_valid = 1'b1;
    bus.data_in   = a;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    bus.pkt_valid = 1'b0;     bus.data_in = 2'd0;       bus.fifo_full = 1'b0;
    bus.fifo_empty_0 = 1'b1;  bus.fifo_empty_1 = 1'b1;  bus.fifo_empty_2 = 1'b1;
    bus.soft_reset_0 = 1'b0;  bus.soft_reset_1 = 1'b0;  bus.soft_reset_2 = 1'b0;
    bus.parity_done = 1'b0;   bus.low_pkt_valid = 1'b0;

    // Reset held for two cycles, then released with pkt_valid low
    tick(); tick();
    check("reset_outs", outs_s, O_DA);
    reset = 1'b1;
    tick();
    check("idle_after_reset", outs_s, O_DA);
    tick();
    check("idle_hold", outs_s, O_DA);

    // Normal packet to FIFO 1 with 10 payload bytes
    wen_cnt = 0;
    header(2'd1);
    check("norm_lfd", outs_s, O_LFD);
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("norm_ld%0d", i), outs_s, O_LD);
      if (i == 9) bus.pkt_valid = 1'b0;
      tick();
    end
    check("norm_lp", outs_s, O_LP);
    tick();
    check("norm_cpe", outs_s, O_CPE);
    tick();
    check("norm_da", outs_s, O_DA);
    check("norm_wen_cnt", 8'(wen_cnt), 8'd11);

    // Full stall for 3 cycles, then LAF back to LD
    header(2'd0);
    check("full_lfd", outs_s, O_LFD);
    tick();
    check("full_ld", outs_s, O_LD);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("full_ffs%0d", i), outs_s, O_FFS);
    end
    bus.fifo_full = 1'b0;
    tick();
    check("full_laf", outs_s, O_LAF);
    tick();
    check("full_ld_again", outs_s, O_LD);

    // Soft reset of an unselected FIFO is ignored, the selected one aborts
    bus.soft_reset_1 = 1'b1;
    tick();
    bus.soft_reset_1 = 1'b0;
    check("srst_other", outs_s, O_LD);
    bus.soft_reset_0 = 1'b1;
    tick();
    bus.soft_reset_0 = 1'b0;
    bus.pkt_valid = 1'b0;
    check("srst_sel", outs_s, O_DA);
    tick();
    check("srst_idle", outs_s, O_DA);

    // Full and pkt_valid low together in LD: parity loaded via LAF then LP
    header(2'd0);
    tick();
    check("fp_ld", outs_s, O_LD);
    bus.fifo_full = 1'b1;
    bus.pkt_valid = 1'b0;
    tick();
    check("fp_ffs", outs_s, O_FFS);
    bus.fifo_full = 1'b0;
    bus.low_pkt_valid = 1'b1;
    tick();
    check("fp_laf", outs_s, O_LAF);
    tick();
    check("fp_lp", outs_s, O_LP);
    bus.low_pkt_valid = 1'b0;
    tick();
    check("fp_cpe", outs_s, O_CPE);
    bus.fifo_full = 1'b1;
    tick();
    check("cpe_full_ffs", outs_s, O_FFS);
    bus.fifo_full = 1'b0;
    tick();
    check("cpe_laf", outs_s, O_LAF);
    bus.parity_done = 1'b1;
    tick();
    bus.parity_done = 1'b0;
    check("laf_parity_done_da", outs_s, O_DA);

    // Wait for FIFO 2 to drain; other FIFOs empty must not release it
    bus.fifo_empty_2 = 1'b0;
    header(2'd2);
    bus.pkt_valid = 1'b0;
    check("wte_enter", outs_s, O_WTE);
    tick();
    check("wte_hold0", outs_s, O_WTE);
    tick();
    check("wte_hold1", outs_s, O_WTE);
    bus.fifo_empty_2 = 1'b1;
    tick();
    check("wte_lfd", outs_s, O_LFD);
    bus.soft_reset_2 = 1'b1;
    tick();
    bus.soft_reset_2 = 1'b0;
    check("lfd_srst_da", outs_s, O_DA);

    // Invalid address 3 stays in DA with no write enable
    bus.pkt_valid = 1'b1;
    bus.data_in   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("addr3_da%0d", i), outs_s, O_DA);
`ifdef ROUTER_FSM_DBG_EN
      check($sformatf("addr3_dbg%0d", i), {5'd0, state_dbg}, 8'd0);
`endif
    end

    // Asynchronous reset in the middle of a packet
    header(2'd1);
    tick();
    check("mid_ld", outs_s, O_LD);
`ifdef ROUTER_FSM_DBG_EN
    check("mid_dbg_ld", {5'd0, state_dbg}, 8'd2);
`endif
    #2 reset = 1'b0;
    #1;
    check("mid_reset_async", outs_s, O_DA);
    bus.pkt_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_reset_idle", outs_s, O_DA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
